// File: rtl/des_iter_core.sv
// Iterative DES engine: ROUNDS_PER_CYCLE Feistel rounds per clock, on-the-fly key schedule.
// Optional abort port enabled by defining DES_ITER_CORE_ABORT_EN.
module des_feistel (
    input  logic [31:0] l_i,
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] l_o,
    output logic [31:0] r_o
);
    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
        8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    // Each box packed row-major, entry 0 in the top nibble.
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    logic [47:0] e;
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;

    always_comb begin
        e = '0;
        for (int i = 0; i < 48; i++) e[6'(47 - i)] = r_i[5'(32 - E_T[i])];
    end

    assign x = e ^ k_i;

    for (genvar b = 0; b < 8; b++) begin : g_sbox
        logic [5:0] six;
        logic [5:0] idx;
        assign six = x[47 - 6*b -: 6];
        assign idx = {six[5], six[0], six[4:1]};
        assign s[31 - 4*b -: 4] = SB[b][8'(255 - 4*int'(idx)) -: 4];
    end

    always_comb begin
        p = '0;
        for (int i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - P_T[i])];
    end

    assign l_o = r_i;
    assign r_o = l_i ^ p;
endmodule

module des_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        decrypt_i,
    input  logic [63:0] key_i,
    input  logic [63:0] data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] data_o,
    output logic        busy_o
`ifdef DES_ITER_CORE_ABORT_EN
    ,
    input  logic        abort_i
`endif
);
    localparam int RPC = ROUNDS_PER_CYCLE;

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
        $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic logic [63:0] ip(input logic [63:0] v);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = v[6'(64 - IP_T[i])];
        return o;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] v);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = v[6'(64 - FP_T[i])];
        return o;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] v);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[6'(55 - i)] = v[6'(64 - PC1_T[i])];
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] v);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = v[6'(56 - PC2_T[i])];
        return o;
    endfunction

    // Decrypt walks the schedule backwards, so its first round uses C16 = C0 unrotated.
    function automatic logic [27:0] rot(input logic [27:0] v, input logic dec,
                                        input logic [4:0] n);
        logic one;
        one = (n == 5'd0) || (n == 5'd1) || (n == 5'd8) || (n == 5'd15);
        if (!dec) return one ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
        if (n == 5'd0) return v;
        return one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        dec_q, dec_d;
    logic [63:0] dout_q, dout_d;
    logic        abort;

`ifdef DES_ITER_CORE_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    logic [31:0] l_w [RPC+1];
    logic [31:0] r_w [RPC+1];
    logic [27:0] c_w [RPC+1];
    logic [27:0] d_w [RPC+1];

    assign l_w[0] = l_q;
    assign r_w[0] = r_q;
    assign c_w[0] = c_q;
    assign d_w[0] = d_q;

    for (genvar g = 0; g < RPC; g++) begin : g_rnd
        logic [4:0]  rn;
        logic [47:0] rk;
        assign rn       = cnt_q + 5'(g);
        assign c_w[g+1] = rot(c_w[g], dec_q, rn);
        assign d_w[g+1] = rot(d_w[g], dec_q, rn);
        assign rk       = pc2({c_w[g+1], d_w[g+1]});
        des_feistel u_feistel (
            .l_i (l_w[g]),
            .r_i (r_w[g]),
            .k_i (rk),
            .l_o (l_w[g+1]),
            .r_o (r_w[g+1])
        );
    end

    assign in_ready_o  = (state_q == S_IDLE) && !abort;
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign data_o      = dout_q;

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        dout_d  = dout_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    state_d    = S_RUN;
                    {l_d, r_d} = ip(data_i);
                    {c_d, d_d} = pc1(key_i);
                    dec_d      = decrypt_i;
                    cnt_d      = '0;
                end
            end
            S_RUN: begin
                l_d   = l_w[RPC];
                r_d   = r_w[RPC];
                c_d   = c_w[RPC];
                d_d   = d_w[RPC];
                cnt_d = cnt_q + 5'(RPC);
                // Register the result on the last round edge so DONE holds it.
                if (cnt_d == 5'd16) begin
                    state_d = S_DONE;
                    dout_d  = fp({r_w[RPC], l_w[RPC]});
                end
            end
            S_DONE: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            dout_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            dout_q  <= dout_d;
        end
    end
endmodule

// File: tb/tb_des_iter_core.sv
// Bench for des_iter_core: five instances (R=1..16) share stimulus; results
// are checked against known vectors and a table-driven DES reference model.
module tb_des_iter_core;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        dec;
    logic        abort;
    logic [63:0] key;
    logic [63:0] data;
    logic [4:0]  rdy;
    logic [4:0]  ov;
    logic [4:0]  bsy;
    logic [63:0] dout [5];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        des_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .in_valid_i  (in_valid),
            .in_ready_o  (rdy[g]),
            .decrypt_i   (dec),
            .key_i       (key),
            .data_i      (data),
            .out_valid_o (ov[g]),
            .out_ready_i (out_ready),
            .data_o      (dout[g]),
            .busy_o      (bsy[g])
`ifdef DES_ITER_CORE_ABORT_EN
            ,
            .abort_i     (abort)
`endif
        );
    end

    // ---------------- reference model ----------------
    int T_IP[$] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    int T_FP[$] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    int T_PC1[$] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                     10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                     63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                     14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    int T_PC2[$] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                     23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                     41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                     44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int T_E[$] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
                   8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                   16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                   24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    int T_P[$] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                   2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    int SHIFTS[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    logic [63:0] SROW[32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    function automatic logic [63:0] perm(input logic [63:0] x, input int win, input int t[$]);
        logic [63:0] o;
        o = '0;
        foreach (t[i]) o = (o << 1) | ((x >> (win - t[i])) & 64'd1);
        return o;
    endfunction

    function automatic logic [63:0] rol28(input logic [63:0] v, input int s);
        return ((v << s) | (v >> (28 - s))) & 64'h0FFF_FFFF;
    endfunction

    function automatic logic [63:0] f_fn(input logic [63:0] r, input logic [63:0] k);
        logic [63:0] e;
        logic [63:0] s;
        int six, row, col;
        e = perm(r, 32, T_E) ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = int'((e >> (42 - 6*b)) & 64'd63);
            row = ((six >> 4) & 2) | (six & 1);
            col = (six >> 1) & 15;
            s = (s << 4) | ((SROW[b*4 + row] >> (60 - 4*col)) & 64'hF);
        end
        return perm(s, 32, T_P);
    endfunction

    function automatic logic [63:0] des_ref(input logic [63:0] k, input logic [63:0] d,
                                            input logic dc);
        logic [63:0] cd, c, dd, lr, l, r, t;
        logic [63:0] ks[16];
        cd = perm(k, 64, T_PC1);
        c  = cd >> 28;
        dd = cd & 64'h0FFF_FFFF;
        for (int i = 0; i < 16; i++) begin
            c = rol28(c, SHIFTS[i]);
            dd = rol28(dd, SHIFTS[i]);
            ks[i] = perm((c << 28) | dd, 56, T_PC2);
        end
        lr = perm(d, 64, T_IP);
        l  = lr >> 32;
        r  = lr & 64'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ f_fn(r, dc ? ks[15-i] : ks[i]);
            l = t;
        end
        return perm((r << 32) | l, 64, T_FP);
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic run_block(input logic [63:0] k, input logic [63:0] d, input logic dc,
                             input logic [63:0] exp);
        int w;
        int lat[5];
        logic [63:0] got[5];
        w = 0;
        while (rdy != 5'h1f && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (rdy != 5'h1f) begin
            check("ready_timeout", 64'(rdy), 64'h1f);
            return;
        end
        key = k;
        data = d;
        dec = dc;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        key = {$urandom, $urandom};
        data = {$urandom, $urandom};
        dec = ~dc;
        check("accepted_busy", 64'(bsy[0]), 64'd1);
        for (int g = 0; g < 5; g++) begin
            lat[g] = -1;
            got[g] = '0;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            for (int g = 0; g < 5; g++)
                if (ov[g] && lat[g] < 0) begin
                    lat[g] = c;
                    got[g] = dout[g];
                end
        end
        for (int g = 0; g < 5; g++) begin
            check($sformatf("latency_r%0d", 1 << g), 64'(lat[g]), 64'(16 >> g));
            check($sformatf("data_r%0d", 1 << g), got[g], exp);
        end
    endtask

    typedef struct {
        logic [63:0] key;
        logic [63:0] data;
        logic        dec;
        logic [63:0] exp;
    } vec_t;

    initial begin
        vec_t tv[4];
        int   w;
        bit   seen;
        logic [63:0] rk, rd;
        logic rdc;

        tv[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405};
        tv[1] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF};
        tv[2] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
        tv[3] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dec = 1'b0;
        abort = 1'b0;
        key = '0;
        data = '0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            check("reset_ready", 64'(rdy[g]), 64'd1);
            check("reset_valid", 64'(ov[g]), 64'd0);
            check("reset_busy", 64'(bsy[g]), 64'd0);
            check("reset_data", dout[g], 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            run_block(tv[i].key, tv[i].data, tv[i].dec, tv[i].exp);

        // Backpressure: result held, inputs ignored, next block right after release.
        key = tv[0].key;
        data = tv[0].data;
        dec = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!ov[0] && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("bp_done", 64'(ov[0]), 64'd1);
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            data = {$urandom, $urandom};
            key = {$urandom, $urandom};
            @(negedge clk);
            check("bp_hold_data", dout[0], tv[0].exp);
            check("bp_ready_low", 64'(rdy[0]), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(rdy[0]), 64'd1);
        check("bp_release_valid", 64'(ov[0]), 64'd0);
        run_block(tv[2].key, tv[2].data, tv[2].dec, tv[2].exp);

        // Reset with the R=1 instance at round counter 7.
        key = tv[0].key;
        data = tv[0].data;
        dec = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 5; g++) begin
            check("midrun_rst_ready", 64'(rdy[g]), 64'd1);
            check("midrun_rst_valid", 64'(ov[g]), 64'd0);
            check("midrun_rst_busy", 64'(bsy[g]), 64'd0);
            check("midrun_rst_data", dout[g], 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ov != 5'd0) seen = 1'b1;
        end
        check("midrun_rst_no_emit", 64'(seen), 64'd0);
        run_block(tv[1].key, tv[1].data, tv[1].dec, tv[1].exp);

`ifdef DES_ITER_CORE_ABORT_EN
        key = tv[0].key;
        data = tv[0].data;
        dec = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_idle_busy", 64'(bsy[0]), 64'd0);
        check("abort_idle_ready", 64'(rdy[0]), 64'd1);
        check("abort_data_clear", dout[0], 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ov != 5'd0) seen = 1'b1;
        end
        check("abort_no_emit", 64'(seen), 64'd0);
        abort = 1'b1;
        in_valid = 1'b1;
        #1;
        check("abort_blocks_ready", 64'(rdy[0]), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        abort = 1'b0;
        #1;
        check("abort_not_accepted", 64'(bsy[0]), 64'd0);
        @(negedge clk);
`endif

        for (int i = 0; i < 20; i++) begin
            rk = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            rdc = 1'($urandom_range(0, 1));
            run_block(rk, rd, rdc, des_ref(rk, rd, rdc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
